// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the RV32I core, sitting directly upstream of the control
// unit. It owns the program counter, runs a request/ready handshake with
// instruction memory, captures each returned word in an instruction register
// and presents the decoded register/function fields to decode.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   imem_req           : fetch request valid
//   imem_addr          : fetch address (equal to the PC)
//   imem_ready         : memory accepts the request and returns data this cycle
//   imem_rdata         : instruction word, valid on imem_req && imem_ready
//   stall              : downstream cannot take the current instruction
//   redirect_valid     : taken branch/jump from execute
//   redirect_pc        : branch/jump target
//   if_valid           : instruction register holds a live instruction
//   if_instr / if_pc   : instruction register and its PC
//   if_pc_plus4        : if_pc + 4, used as the JAL/JALR link value
//   opcode, funct3, funct7, rd, rs1, rs2 : combinational slices of if_instr
//   if_fault           : sticky misaligned-target fault
//
// Configuration macro
//   IFU_MISALIGN_FAULT_EN : when defined, a redirect whose target has
//   nonzero low bits halts fetch in a FAULT state until an aligned redirect
//   or reset. When undefined, the low two target bits are forced to zero,
//   if_fault is tied low and no FSM is built.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        if_fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instrPc_q, instrPc_d;
  logic        valid_q, valid_d;
  logic [31:0] redirTarget;
  logic        fetchEnable;
  logic        accept;

`ifdef IFU_MISALIGN_FAULT_EN
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   misaligned;

  // Misaligned targets are kept as-is so the faulting address stays visible
  // in the PC while the unit is halted.
  assign redirTarget = redirect_pc;
  assign misaligned  = |redirect_pc[1:0];
  assign fetchEnable = (state_q == RUN);
  assign if_fault    = (state_q == FAULT);
`else
  logic unusedRedirectLsbs;

  // Without fault support the target is simply forced onto a word boundary.
  assign redirTarget        = {redirect_pc[31:2], 2'b00};
  assign unusedRedirectLsbs = ^redirect_pc[1:0];
  assign fetchEnable        = 1'b1;
  assign if_fault           = 1'b0;
`endif

  // A request is held back while a live instruction is stalled, so the
  // register is never overwritten. Releasing stall re-enables the request
  // in the same cycle. Reset suppresses the request outright.
  assign imem_req  = !rst && fetchEnable && !(valid_q && stall);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  // Next-state logic. Redirect wins over accept (the returned word belongs
  // to the wrong path) and over stall; otherwise an accept refills the
  // instruction register, and an unstalled live instruction is consumed.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instrPc_d = instrPc_q;
    valid_d   = valid_q;
`ifdef IFU_MISALIGN_FAULT_EN
    state_d   = state_q;
`endif
    if (redirect_valid) begin
      pc_d    = redirTarget;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
`ifdef IFU_MISALIGN_FAULT_EN
      state_d = misaligned ? FAULT : RUN;
`endif
    end else if (accept) begin
      instr_d   = imem_rdata;
      instrPc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instrPc_q <= RESET_PC;
      valid_q   <= 1'b0;
`ifdef IFU_MISALIGN_FAULT_EN
      state_q   <= RUN;
`endif
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instrPc_q <= instrPc_d;
      valid_q   <= valid_d;
`ifdef IFU_MISALIGN_FAULT_EN
      state_q   <= state_d;
`endif
    end
  end

  // Outputs to decode: register contents and fixed RV32I field slices.
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = instrPc_q;
  assign if_pc_plus4 = instrPc_q + 32'd4;
  assign opcode      = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign funct3      = instr_q[14:12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign funct7      = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        if_fault;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        stall;
    logic        redirV;
    logic [31:0] rdata;
    logic [31:0] redirPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[18];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .if_fault       (if_fault)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic stl,
                               input logic rv, input logic [31:0] data,
                               input logic [31:0] rpc);
    rst            = r;
    imem_ready     = rdy;
    stall          = stl;
    redirect_valid = rv;
    imem_rdata     = data;
    redirect_pc    = rpc;
  endtask

  // Move from the check point (negedge) to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed vector table: inputs applied for one cycle, outputs checked
    // mid-cycle (registered values reflect the previous edge).
    //           rst   rdy   stl   rv    rdata          redirPc        req   addr           vld   instr          pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, NOP,           32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00500093,  32'h0,         1'b1, 32'h0,         1'b0, NOP,           32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00A00113,  32'h0,         1'b1, 32'h4,         1'b1, 32'h00500093,  32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8,         1'b1, 32'h00A00113,  32'h4};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8,         1'b0, 32'h00A00113,  32'h4};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8,         1'b0, 32'h00A00113,  32'h4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40B50533,  32'h0,         1'b1, 32'h8,         1'b0, 32'h00A00113,  32'h4};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF,  32'h0,         1'b0, 32'hC,         1'b1, 32'h40B50533,  32'h8};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF,  32'h0,         1'b0, 32'hC,         1'b1, 32'h40B50533,  32'h8};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hC,         1'b1, 32'h40B50533,  32'h8};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111,  32'h100,       1'b1, 32'hC,         1'b0, 32'h40B50533,  32'h8};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00C00193,  32'h0,         1'b1, 32'h100,       1'b0, NOP,           32'h8};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b1, 32'h00C00193,  32'h100};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFFFFFC,  1'b1, 32'h104,       1'b0, 32'h00C00193,  32'h100};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00100213,  32'h0,         1'b1, 32'hFFFFFFFC,  1'b0, NOP,           32'h100};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         1'b1, 32'h00100213,  32'hFFFFFFFC};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h22222222,  32'h0,         1'b0, 32'h0,         1'b0, 32'h00100213,  32'hFFFFFFFC};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         1'b0, NOP,           32'h0};

    // Hold reset across two edges so every register is initialised.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].stall, vecs[i].redirV,
                    vecs[i].rdata, vecs[i].redirPc);
      @(negedge clk);
      checkOutput($sformatf("v%0d.req", i),    {31'b0, imem_req},   {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d.addr", i),   imem_addr,           vecs[i].expAddr);
      checkOutput($sformatf("v%0d.valid", i),  {31'b0, if_valid},   {31'b0, vecs[i].expValid});
      checkOutput($sformatf("v%0d.instr", i),  if_instr,            vecs[i].expInstr);
      checkOutput($sformatf("v%0d.pc", i),     if_pc,               vecs[i].expPc);
      checkOutput($sformatf("v%0d.pc4", i),    if_pc_plus4,         vecs[i].expPc + 32'd4);
      checkOutput($sformatf("v%0d.opcode", i), {25'b0, opcode},     {25'b0, vecs[i].expInstr[6:0]});
      checkOutput($sformatf("v%0d.rd", i),     {27'b0, rd},         {27'b0, vecs[i].expInstr[11:7]});
      checkOutput($sformatf("v%0d.funct3", i), {29'b0, funct3},     {29'b0, vecs[i].expInstr[14:12]});
      checkOutput($sformatf("v%0d.rs1", i),    {27'b0, rs1},        {27'b0, vecs[i].expInstr[19:15]});
      checkOutput($sformatf("v%0d.rs2", i),    {27'b0, rs2},        {27'b0, vecs[i].expInstr[24:20]});
      checkOutput($sformatf("v%0d.funct7", i), {25'b0, funct7},     {25'b0, vecs[i].expInstr[31:25]});
      checkOutput($sformatf("v%0d.fault", i),  {31'b0, if_fault},   32'h0);
      nextCycle();
    end

    // Spot checks of the decode fields on known words.
    checkOutput("sub.funct7.const", {25'b0, vecs[8].expInstr[31:25]}, 32'h20);

    // Load a live instruction, then redirect to a misaligned target while
    // stalled: the redirect must override the stall.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333, 32'h102);
    @(negedge clk);
    checkOutput("stallRedir.valid", {31'b0, if_valid}, 32'h1);
    checkOutput("stallRedir.req",   {31'b0, imem_req}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("misalign.valid", {31'b0, if_valid}, 32'h0);
    checkOutput("misalign.instr", if_instr, NOP);
`ifdef IFU_MISALIGN_FAULT_EN
    checkOutput("misalign.fault", {31'b0, if_fault}, 32'h1);
    checkOutput("misalign.req",   {31'b0, imem_req}, 32'h0);
    checkOutput("misalign.addr",  imem_addr, 32'h102);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h00700293, 32'h0);
    @(negedge clk);
    checkOutput("fault.hold.req",   {31'b0, imem_req}, 32'h0);
    checkOutput("fault.hold.fault", {31'b0, if_fault}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200);
    @(negedge clk);
    checkOutput("fault.sticky",   {31'b0, if_fault}, 32'h1);
    checkOutput("fault.valid",    {31'b0, if_valid}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("exit.fault", {31'b0, if_fault}, 32'h0);
    checkOutput("exit.req",   {31'b0, imem_req}, 32'h1);
    checkOutput("exit.addr",  imem_addr, 32'h200);
`else
    checkOutput("misalign.fault", {31'b0, if_fault}, 32'h0);
    checkOutput("misalign.req",   {31'b0, imem_req}, 32'h1);
    checkOutput("misalign.addr",  imem_addr, 32'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h00700293, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("aligned.valid", {31'b0, if_valid}, 32'h1);
    checkOutput("aligned.pc",    if_pc, 32'h100);
    checkOutput("aligned.instr", if_instr, 32'h00700293);
    checkOutput("aligned.rd",    {27'b0, rd}, 32'h5);
    checkOutput("aligned.fault", {31'b0, if_fault}, 32'h0);
    checkOutput("aligned.addr",  imem_addr, 32'h104);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage of the RV32I core, directly upstream of the control unit.
- Holds the PC and runs a request/ready handshake with instruction memory.
- Latches each returned word into an instruction register and presents `opcode`/`funct3`/`funct7` plus register fields to decode.
- Accepts branch/jump redirects from execute and stall back-pressure from downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000 — PC fetched first after reset.
- `NOP_INSTR`, default 32'h0000_0013 — instruction-register value at reset/flush (ADDI x0,x0,0).
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `imem_req` out 1 — fetch request valid.
- `imem_addr` out 32 — fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1 — memory accepts request and returns data the same cycle.
- `imem_rdata` in 32 — instruction word, valid when `imem_req`&&`imem_ready`.
- `stall` in 1 — downstream cannot take the current instruction.
- `redirect_valid` in 1 — taken branch/jump.
- `redirect_pc` in 32 — target PC.
- `if_valid` out 1 — instruction register holds a live instruction.
- `if_instr` out 32 — instruction register.
- `if_pc` out 32 — PC of `if_instr`.
- `if_pc_plus4` out 32 — `if_pc`+4, for JAL/JALR link.
- `opcode` out 7 — `if_instr[6:0]`.
- `funct3` out 3 — `if_instr[14:12]`.
- `funct7` out 7 — `if_instr[31:25]`.
- `rd`, `rs1`, `rs2` out 5 each — `[11:7]`, `[19:15]`, `[24:20]`.
- `if_fault` out 1 — misaligned-target fault (see Configuration).

## Operation
- States:
  - `RUN`: fetching.
  - `FAULT`: halted on misaligned target.
- Registers:
  - `pc` (next address to fetch).
  - Instruction register: `if_instr`, `if_pc`, `if_valid`.
- `imem_addr` = `pc`.
- `imem_req` = 1 in `RUN`, except when `if_valid`&&`stall`.
- Accept = `imem_req`&&`imem_ready`. On accept:
  - `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+4.
  - PC arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- No accept, `if_valid`=1, `stall`=0: instruction consumed, `if_valid`<=0.
- `if_valid`=1 and `stall`=1: instruction register and `pc` hold; no request issued.
- Redirect (`redirect_valid`=1), any state:
  - `pc`<=`redirect_pc`, `if_valid`<=0, `if_instr`<=`NOP_INSTR`.
  - Any same-cycle accept data is discarded.
  - Redirect overrides `stall`.
- Priority: `rst` > redirect > accept > consume/hold.
- Decode field outputs are purely combinational slices of `if_instr`.
- Reset values:
  - `pc`=`RESET_PC`, state=`RUN`.
  - `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=`RESET_PC`, `if_fault`=0.
  - `imem_req` is 0 during the reset cycle.

## Timing
- First request in the first cycle after `rst` deasserts, with `imem_addr`=`RESET_PC`.
- Latency:
  - Accept at edge N → `if_valid`=1 with new instruction in cycle N+1.
  - Zero-wait memory sustains one instruction per cycle.
- Redirect asserted in cycle N:
  - Cycle N+1: `imem_addr`=`redirect_pc`, `if_valid`=0.
  - Earliest redirected instruction is valid in N+2.
- `stall` released in cycle N: request reissues in the same cycle N (combinational on `stall`).
- `rst` asserted mid-handshake: the pending request is abandoned and the pending response ignored.

## Configuration
- Macro: `IFU_MISALIGN_FAULT_EN`.
- Defined:
  - Redirect with `redirect_pc[1:0]`≠0 enters `FAULT`.
  - In `FAULT`: `if_fault`=1 (sticky), `imem_req`=0, `if_valid`=0, `pc` holds the faulting target.
  - Exit only on an aligned redirect (→`RUN`, `if_fault`<=0) or `rst`.
  - A misaligned redirect while in `FAULT` stays in `FAULT` and updates `pc`.
- Undefined:
  - `redirect_pc[1:0]` is forced to 00.
  - `if_fault` is tied 0 and `FAULT` is not built.

## Test plan
- Reset then zero-wait memory returning 0x00500093, 0x00A00113 → `if_pc` 0x0, 0x4 on consecutive cycles; `opcode`=0x13, `rd`=1 then 2; `if_pc_plus4`=0x4, 0x8.
- `imem_ready` low 3 cycles at addr 0x8 → `imem_addr` stays 0x8, `if_valid`=0 after consume; word appears one cycle after `imem_ready`.
- `stall`=1 for 2 cycles with `if_instr`=0x40B50533 (SUB) → `if_instr`, `if_pc` and `funct7`=0x20 all hold, `imem_req`=0; `pc` advances by exactly 4 once released.
- `redirect_valid` with `redirect_pc`=0x100 in the same cycle as an accept at 0xC → 0xC data discarded; next `imem_addr`=0x100; first valid `if_pc`=0x100.
- Fetch at 0xFFFF_FFFC → next `imem_addr`=0x0.
- With `IFU_MISALIGN_FAULT_EN`: redirect to 0x102 → `if_fault`=1, `imem_req`=0 until redirect to 0x200. Without the macro: same redirect fetches 0x100 and `if_fault` stays 0.
